// File: rtl/core_controller.sv
// Warp-scheduling controller for a SIMT core: sequences fetch/decode/memory/execute/update
// and round-robins warps. Optional divergence detection under CORE_DIVERGENCE_CHECK_EN.
module core_controller #(
    parameter int unsigned THREADS_PER_WARP   = 4,
    parameter int unsigned MAX_WARPS_PER_CORE = 4,
    parameter int unsigned PC_BITS            = 8,
    parameter int unsigned WARP_ID_BITS       = (MAX_WARPS_PER_CORE > 1) ? $clog2(MAX_WARPS_PER_CORE) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [7:0]                           thread_count,
    output logic                                 fetch_valid,
    input  logic                                 fetch_ready,
    input  logic                                 decoded_ret,
    input  logic [THREADS_PER_WARP-1:0]          lsu_busy,
    input  logic [THREADS_PER_WARP*PC_BITS-1:0]  next_pc,
    output logic [2:0]                           core_state,
    output logic [WARP_ID_BITS-1:0]              current_warp_id,
    output logic [PC_BITS-1:0]                   current_pc,
    output logic [THREADS_PER_WARP-1:0]          active_mask,
    output logic                                 done,
    output logic                                 diverged
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_REQUEST = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_EXECUTE = 3'd5;
    localparam logic [2:0] S_UPDATE  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int unsigned CNT_W = $clog2(MAX_WARPS_PER_CORE + 1);
    localparam int unsigned IDX_W = WARP_ID_BITS + 16;

    logic [2:0]                    state_q, state_d;
    logic [WARP_ID_BITS-1:0]       warp_id_q, warp_id_d;
    logic [PC_BITS-1:0]            pc_q [MAX_WARPS_PER_CORE];
    logic [PC_BITS-1:0]            pc_d [MAX_WARPS_PER_CORE];
    logic [MAX_WARPS_PER_CORE-1:0] done_flags_q, done_flags_d;

    logic [8:0]                    warps_raw;
    logic [CNT_W-1:0]              num_warps;
    logic [PC_BITS-1:0]            lead_pc_c;
    logic [MAX_WARPS_PER_CORE-1:0] done_flags_upd_c;
    logic [WARP_ID_BITS-1:0]       next_warp_c;
    logic                          next_found_c;
    int                            cand_c;

    // Launched warp count, clamped to the available contexts
    assign warps_raw = (9'(thread_count) + 9'(THREADS_PER_WARP - 1)) / 9'(THREADS_PER_WARP);
    assign num_warps = (warps_raw > 9'(MAX_WARPS_PER_CORE)) ? CNT_W'(MAX_WARPS_PER_CORE)
                                                             : CNT_W'(warps_raw);

    always_comb begin
        for (int i = 0; i < int'(THREADS_PER_WARP); i++) begin
            active_mask[i] = (IDX_W'(warp_id_q) * IDX_W'(THREADS_PER_WARP) + IDX_W'(i))
                             < IDX_W'(thread_count);
        end
    end

    // Next PC comes from the lowest-index active thread
    always_comb begin
        lead_pc_c = '0;
        for (int i = int'(THREADS_PER_WARP) - 1; i >= 0; i--) begin
            if (active_mask[i]) lead_pc_c = next_pc[i*PC_BITS +: PC_BITS];
        end
    end

    // Round-robin from current+1; the current warp is the last candidate
    always_comb begin
        done_flags_upd_c = done_flags_q;
        if (decoded_ret) done_flags_upd_c[warp_id_q] = 1'b1;
        next_warp_c  = warp_id_q;
        next_found_c = 1'b0;
        cand_c       = 0;
        for (int k = int'(MAX_WARPS_PER_CORE); k >= 1; k--) begin
            cand_c = int'(warp_id_q) + k;
            if (cand_c >= int'(num_warps)) cand_c = cand_c - int'(num_warps);
            if (k <= int'(num_warps) && cand_c < int'(num_warps)
                && !done_flags_upd_c[WARP_ID_BITS'(cand_c)]) begin
                next_warp_c  = WARP_ID_BITS'(cand_c);
                next_found_c = 1'b1;
            end
        end
    end

`ifdef CORE_DIVERGENCE_CHECK_EN
    logic diverged_q, diverged_d, diverge_c;

    always_comb begin
        diverge_c = 1'b0;
        for (int i = 0; i < int'(THREADS_PER_WARP); i++) begin
            if (active_mask[i] && next_pc[i*PC_BITS +: PC_BITS] != lead_pc_c) diverge_c = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) diverged_q <= 1'b0;
        else       diverged_q <= diverged_d;
    end

    assign diverged = diverged_q;
`else
    assign diverged = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        warp_id_d    = warp_id_q;
        pc_d         = pc_q;
        done_flags_d = done_flags_q;
`ifdef CORE_DIVERGENCE_CHECK_EN
        diverged_d   = diverged_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d         = '{default: '0};
                    done_flags_d = '0;
                    warp_id_d    = '0;
`ifdef CORE_DIVERGENCE_CHECK_EN
                    diverged_d   = 1'b0;
`endif
                    state_d      = (thread_count == 8'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   if (fetch_ready) state_d = S_DECODE;
            S_DECODE:  state_d = S_REQUEST;
            S_REQUEST: state_d = S_WAIT;
            S_WAIT:    if ((lsu_busy & active_mask) == '0) state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_UPDATE;
            S_UPDATE: begin
                done_flags_d = done_flags_upd_c;
                if (!decoded_ret) begin
                    pc_d[warp_id_q] = lead_pc_c;
`ifdef CORE_DIVERGENCE_CHECK_EN
                    diverged_d = diverged_q | diverge_c;
`endif
                end
                if (next_found_c) begin
                    warp_id_d = next_warp_c;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_DONE;
                end
            end
            S_DONE:    if (!start) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            warp_id_q    <= '0;
            done_flags_q <= '0;
            pc_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            warp_id_q    <= warp_id_d;
            done_flags_q <= done_flags_d;
            pc_q         <= pc_d;
        end
    end

    assign core_state      = state_q;
    assign current_warp_id = warp_id_q;
    assign current_pc      = pc_q[warp_id_q];
    assign fetch_valid     = (state_q == S_FETCH);
    assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_core_controller.sv
// Self-checking bench for core_controller: launch vector table, directed corner sequences,
// and randomized kernels checked against a per-instruction warp scheduling model.
module tb_core_controller;

    localparam int T  = 4;
    localparam int W  = 4;
    localparam int PB = 8;

    logic            clk = 1'b0;
    logic            reset, start, fetch_valid, fetch_ready, decoded_ret, done, diverged;
    logic [7:0]      thread_count;
    logic [T-1:0]    lsu_busy, active_mask;
    logic [T*PB-1:0] next_pc;
    logic [2:0]      core_state;
    logic [1:0]      current_warp_id;
    logic [PB-1:0]   current_pc;

    core_controller dut (
        .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .decoded_ret(decoded_ret),
        .lsu_busy(lsu_busy), .next_pc(next_pc), .core_state(core_state),
        .current_warp_id(current_warp_id), .current_pc(current_pc),
        .active_mask(active_mask), .done(done), .diverged(diverged)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-warp PC and retirement, current warp, sticky divergence
    int m_tc, m_nw, m_cur;
    int m_pc [W];
    bit m_done [W];
    bit m_div;
    int order_q [$];

    typedef struct {
        int tc;
        int exp_state;
        int exp_mask;
        int exp_done;
    } vec_t;
    vec_t vt [5];

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_mask(int w);
        int m = 0;
        for (int i = 0; i < T; i++) if (w * T + i < m_tc) m |= (1 << i);
        return m;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic launch(int tc);
        thread_count = 8'(tc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_tc = tc;
        m_nw = (tc + T - 1) / T;
        if (m_nw > W) m_nw = W;
        for (int w = 0; w < W; w++) begin m_pc[w] = 0; m_done[w] = 1'b0; end
        m_cur = 0;
        m_div = 1'b0;
        chk("launch_state", int'(core_state), (tc == 0) ? 7 : 1);
        chk("launch_diverged", int'(diverged), 0);
    endtask

    // One instruction of the current warp, entered and left at a negedge
    task automatic step(bit ret, logic [T*PB-1:0] npc, logic [T-1:0] busy, int bw, int fd);
        int wc, exp_wc, lead, nxt;
        bit found;
        if (core_state != 3'd1) begin
            chk("step_in_fetch", int'(core_state), 1);
            return;
        end
        chk("warp_id", int'(current_warp_id), m_cur);
        chk("pc", int'(current_pc), m_pc[m_cur]);
        chk("mask", int'(active_mask), m_mask(m_cur));
        order_q.push_back(m_cur);
        fetch_ready = 1'b0;
        for (int i = 0; i < fd; i++) @(negedge clk);
        chk("fetch_hold", int'(fetch_valid), 1);
        fetch_ready = 1'b1;
        decoded_ret = ret;
        next_pc = npc;
        @(negedge clk);
        fetch_ready = 1'b0;
        chk("decode", int'(core_state), 2);
        @(negedge clk);
        chk("request", int'(core_state), 3);
        lsu_busy = busy;
        @(negedge clk);
        wc = 0;
        while (core_state == 3'd4 && wc < 50) begin
            wc++;
            if (wc > bw) lsu_busy = '0;
            @(negedge clk);
        end
        lsu_busy = '0;
        exp_wc = ((int'(busy) & m_mask(m_cur)) != 0) ? bw + 1 : 1;
        chk("wait_len", wc, exp_wc);
        chk("execute", int'(core_state), 5);
        @(negedge clk);
        chk("update", int'(core_state), 6);
        @(negedge clk);
        decoded_ret = 1'b0;
        if (ret) begin
            m_done[m_cur] = 1'b1;
        end else begin
            lead = 0;
            for (int i = T - 1; i >= 0; i--) if (m_mask(m_cur) & (1 << i)) lead = i;
            m_pc[m_cur] = int'(npc[lead*PB +: PB]);
`ifdef CORE_DIVERGENCE_CHECK_EN
            for (int i = 0; i < T; i++)
                if ((m_mask(m_cur) & (1 << i)) != 0 && int'(npc[i*PB +: PB]) != m_pc[m_cur]) m_div = 1'b1;
`endif
        end
        found = 1'b0;
        for (int k = 1; k <= m_nw; k++) begin
            nxt = (m_cur + k) % m_nw;
            if (!m_done[nxt]) begin
                m_cur = nxt;
                found = 1'b1;
                break;
            end
        end
        chk("after_update", int'(core_state), found ? 1 : 7);
        chk("done", int'(done), found ? 0 : 1);
        chk("diverged", int'(diverged), int'(m_div));
    endtask

    initial begin
        logic [T*PB-1:0] npc;
        logic [PB-1:0]   base;
        int              icount [W];
        int              tc, guard;

        reset = 1'b1; start = 1'b0; thread_count = 8'd6; fetch_ready = 1'b0;
        decoded_ret = 1'b0; lsu_busy = '0; next_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", int'(core_state), 0);
        chk("rst_warp", int'(current_warp_id), 0);
        chk("rst_pc", int'(current_pc), 0);
        chk("rst_fetch_valid", int'(fetch_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diverged", int'(diverged), 0);
        chk("rst_mask", int'(active_mask), 4'hf);
        reset = 1'b0;
        @(negedge clk);

        // Launch table: state/mask/done one cycle after start
        vt[0] = '{0, 7, 4'h0, 1};
        vt[1] = '{1, 1, 4'h1, 0};
        vt[2] = '{3, 1, 4'h7, 0};
        vt[3] = '{6, 1, 4'hf, 0};
        vt[4] = '{255, 1, 4'hf, 0};
        for (int v = 0; v < 5; v++) begin
            pulse_reset();
            thread_count = 8'(vt[v].tc);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("vec_state", int'(core_state), vt[v].exp_state);
            chk("vec_mask", int'(active_mask), vt[v].exp_mask);
            chk("vec_done", int'(done), vt[v].exp_done);
        end

        // Zero threads: DONE while start held, IDLE the cycle after start drops
        pulse_reset();
        thread_count = 8'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_done_state", int'(core_state), 7);
        chk("zero_done", int'(done), 1);
        @(negedge clk);
        chk("zero_hold", int'(core_state), 7);
        start = 1'b0;
        @(negedge clk);
        chk("zero_idle", int'(core_state), 0);
        chk("zero_idle_done", int'(done), 0);

        // Two warps, two instructions then RET each: strict alternation
        pulse_reset();
        launch(8);
        order_q.delete();
        for (int w = 0; w < W; w++) icount[w] = 0;
        guard = 0;
        while (core_state == 3'd1 && guard < 20) begin
            guard++;
            npc = {T{8'(m_pc[m_cur] + 1)}};
            step(icount[m_cur] == 2, npc, '0, 0, 0);
            icount[order_q[$]]++;
        end
        chk("rr_count", order_q.size(), 6);
        for (int i = 0; i < order_q.size() && i < 6; i++) chk("rr_order", order_q[i], i % 2);
        chk("rr_done", int'(done), 1);
        @(negedge clk);

        // Partial warp masking and a 5-cycle WAIT stall
        pulse_reset();
        launch(6);
        step(1'b0, {T{8'h10}}, 4'b0001, 4, 0);
        step(1'b0, {T{8'h20}}, 4'b1100, 3, 1);
        guard = 0;
        while (core_state == 3'd1 && guard < 10) begin
            guard++;
            step(1'b1, '0, '0, 0, 0);
        end
        chk("mask_end", int'(core_state), 7);
        @(negedge clk);

        // Divergent next PCs: lowest thread wins, flag per build
        pulse_reset();
        launch(4);
        step(1'b0, {8'h05, 8'h05, 8'h07, 8'h05}, '0, 0, 0);
        chk("div_pc", int'(current_pc), 5);
        step(1'b1, '0, '0, 0, 0);
        @(negedge clk);

        // Reset in the middle of WAIT, then relaunch from PC 0
        pulse_reset();
        launch(8);
        step(1'b0, {T{8'h33}}, '0, 0, 0);
        fetch_ready = 1'b1;
        @(negedge clk);
        fetch_ready = 1'b0;
        @(negedge clk);
        lsu_busy = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_wait", int'(core_state), 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_state", int'(core_state), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_pc", int'(current_pc), 0);
        @(negedge clk);
        reset = 1'b0;
        lsu_busy = '0;
        launch(8);
        step(1'b0, {T{8'h01}}, '0, 0, 0);
        @(negedge clk);

        // Randomized kernels
        for (int r = 0; r < 10; r++) begin
            pulse_reset();
            tc = $urandom_range(0, 20);
            launch(tc);
            guard = 0;
            while (core_state == 3'd1 && guard < 200) begin
                guard++;
                base = 8'($urandom);
                for (int i = 0; i < T; i++)
                    npc[i*PB +: PB] = ($urandom_range(0, 5) == 0) ? 8'($urandom) : base;
                step($urandom_range(0, 3) == 0, npc, 4'($urandom), $urandom_range(0, 3),
                     $urandom_range(0, 2));
            end
            chk("rand_end", int'(core_state), 7);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/core_controller.md
CORE_CONTROLLER -- requirements
Module: core_controller

Interface
REQ-001 SHALL have parameter THREADS_PER_WARP, default 4, threads executed in lockstep per warp.
REQ-002 SHALL have parameter MAX_WARPS_PER_CORE, default 4, number of warp contexts (PC plus done flag).
REQ-003 SHALL have parameter PC_BITS, default 8, program counter width.
REQ-004 SHALL have parameter WARP_ID_BITS, default max(1, $clog2(MAX_WARPS_PER_CORE)), warp index width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1, launch request; level-sensitive.
REQ-008 SHALL have port thread_count, input, 8, number of threads for this core.
REQ-009 SHALL have port fetch_valid, output, 1, instruction fetch request.
REQ-010 SHALL have port fetch_ready, input, 1, fetched instruction available.
REQ-011 SHALL have port decoded_ret, input, 1, current instruction is RET.
REQ-012 SHALL have port lsu_busy, input, THREADS_PER_WARP, per-thread memory operation outstanding.
REQ-013 SHALL have port next_pc, input, THREADS_PER_WARP*PC_BITS, per-thread next PC; thread i in slice [i*PC_BITS +: PC_BITS].
REQ-014 SHALL have port core_state, output, 3, state broadcast to datapath.
REQ-015 SHALL have port current_warp_id, output, WARP_ID_BITS, warp being executed.
REQ-016 SHALL have port current_pc, output, PC_BITS, PC of current warp.
REQ-017 SHALL have port active_mask, output, THREADS_PER_WARP, bit i set when thread (current_warp_id*THREADS_PER_WARP+i) < thread_count.
REQ-018 SHALL have port done, output, 1, kernel complete on this core.
REQ-019 SHALL have port diverged, output, 1, sticky divergence flag.

Function
REQ-020 SHALL encode states IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7 on core_state.
REQ-021 IDLE with start=1 SHALL clear all warp PCs and done flags and set current_warp_id=0; it SHALL go to FETCH, or to DONE when thread_count=0.
REQ-022 Warp count SHALL be ceil(thread_count/THREADS_PER_WARP), computed at 9 bits and clamped to MAX_WARPS_PER_CORE.
REQ-023 FETCH SHALL assert fetch_valid combinationally and hold until fetch_ready=1, then go to DECODE.
REQ-024 DECODE, REQUEST and EXECUTE SHALL each last exactly one cycle; the sequence is DECODE->REQUEST->WAIT and EXECUTE->UPDATE.
REQ-025 WAIT SHALL remain while (lsu_busy & active_mask) != 0, otherwise go to EXECUTE; busy bits of inactive threads are ignored.
REQ-026 UPDATE with decoded_ret=1 SHALL set the current warp's done flag and leave its PC unchanged.
REQ-027 UPDATE with decoded_ret=0 SHALL load the current warp PC with next_pc of the lowest-index active thread.
REQ-028 After UPDATE the next warp SHALL be chosen round-robin starting at (current+1) mod warp count, skipping done warps; the current warp is eligible last.
REQ-029 If all launched warps are done after UPDATE, the block SHALL go to DONE.
REQ-030 DONE SHALL hold done=1 and go to IDLE (done=0) in the cycle after start is sampled 0.
REQ-031 A non-ret instruction with single-cycle memory timing SHALL take 6 cycles from FETCH entry with fetch_ready=1 to the next FETCH.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE, including in the middle of an operation.
REQ-033 During reset, core_state, current_warp_id, current_pc, fetch_valid, done, diverged and all warp PCs and flags SHALL be 0; active_mask SHALL be derived from warp 0.

Configuration
REQ-034 With macro CORE_DIVERGENCE_CHECK_EN defined, UPDATE with decoded_ret=0 SHALL set diverged when any active thread's next_pc differs from the lowest active thread's. diverged is sticky until reset or a new launch from IDLE, and execution continues.
REQ-035 Without CORE_DIVERGENCE_CHECK_EN, diverged SHALL be tied to 0 and no comparison logic SHALL be built.

Verification
REQ-036 T=4, W=4, thread_count=8, each warp runs 2 non-ret instructions then RET: warp order 0,1,0,1,0,1; done=1 after the 6th UPDATE.
REQ-037 thread_count=6: active_mask=4'b1111 for warp 0 and 4'b0011 for warp 1; lsu_busy=4'b1100 on warp 1 causes no WAIT stall.
REQ-038 lsu_busy=4'b0001 held for 5 cycles on warp 0 -> WAIT lasts 5 cycles, EXECUTE on the 6th cycle.
REQ-039 thread_count=0 with start=1 -> DONE on the next cycle with done=1; start=0 -> IDLE with done=0.
REQ-040 reset pulsed during WAIT -> core_state=0 and done=0 at once; a relaunch restarts from PC 0.
REQ-041 With CORE_DIVERGENCE_CHECK_EN, next_pc={8'h05,8'h05,8'h07,8'h05} with all 4 threads active -> diverged=1 and warp PC=8'h05; without the macro, diverged=0.
